pmp_check_arb: RTL and testbench

Shares one combinational `pmp` checker between the instruction-fetch and LSU requesters, in the CVA6 PMP formal environment.
- Arbitrates round-robin, drives the shared checker with the granted request, and registers each verdict into a per-requester response slot with valid/ready back-pressure.
- Keeps saturating deny counters for debug and formal cover points.
- Sits between the IF/LSU front-ends and a single `pmp` instance. This replaces the two instances that `pmp_data_if` uses today.

---
 rtl/pmp_formal_pkg.sv | 32 +++
 rtl/pmp_rr_arb2.sv | 46 ++++
 rtl/pmp_check_arb.sv | 122 ++++++++++++
 tb/tb_pmp_check_arb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pmp_formal_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmp_formal_pkg : shared types for the arbitrated PMP check path
// Revision: 1.0
// ----------------------------------------------------------------------------
package pmp_formal_pkg;

  // Local stand-ins for the riscv privilege / PMP access encodings
  typedef logic [1:0] priv_lvl_t;
  typedef logic [2:0] pmp_access_t;

  localparam priv_lvl_t   c_PRIV_U      = 2'b00;
  localparam priv_lvl_t   c_PRIV_S      = 2'b01;
  localparam priv_lvl_t   c_PRIV_M      = 2'b11;
  localparam pmp_access_t c_ACCESS_NONE  = 3'b000;
  localparam pmp_access_t c_ACCESS_READ  = 3'b001;
  localparam pmp_access_t c_ACCESS_WRITE = 3'b010;
  localparam pmp_access_t c_ACCESS_EXEC  = 3'b100;

  typedef enum logic {
    PMP_REQ_IF  = 1'b0,
    PMP_REQ_LSU = 1'b1
  } last_grant_t;

  typedef struct packed {
    logic valid;
    logic allow;
    logic store;
  } pmp_check_rsp_t;

endpackage : pmp_formal_pkg
`default_nettype wire

// File: rtl/pmp_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmp_rr_arb2 : two-input round-robin grant, IF vs LSU, with enable gate
// Revision: 1.0
// ----------------------------------------------------------------------------
module pmp_rr_arb2
  import pmp_formal_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req_if_i,
  input  logic req_lsu_i,
  output logic gnt_if_o,
  output logic gnt_lsu_o
);

  last_grant_t r_last;

  // On conflict the requester not served last time wins
  always_comb begin
    gnt_if_o  = 1'b0;
    gnt_lsu_o = 1'b0;
    if (en_i) begin
      if (req_if_i && req_lsu_i) begin
        if (r_last == PMP_REQ_LSU) gnt_if_o  = 1'b1;
        else                       gnt_lsu_o = 1'b1;
      end else begin
        gnt_if_o  = req_if_i;
        gnt_lsu_o = req_lsu_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= PMP_REQ_LSU;
    end else if (gnt_if_o) begin
      r_last <= PMP_REQ_IF;
    end else if (gnt_lsu_o) begin
      r_last <= PMP_REQ_LSU;
    end
  end

endmodule : pmp_rr_arb2
`default_nettype wire

// File: rtl/pmp_check_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmp_check_arb : shares one combinational pmp checker between IF and LSU
// Revision: 1.0
// ----------------------------------------------------------------------------
module pmp_check_arb
  import pmp_formal_pkg::*;
#(
  parameter int PLEN  = 34,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [PLEN-1:0]   if_req_paddr_i,
  input  logic [1:0]        if_req_priv_i,
  output logic              if_rsp_valid_o,
  input  logic              if_rsp_ready_i,
  output logic              if_rsp_allow_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [PLEN-1:0]   lsu_req_paddr_i,
  input  logic [1:0]        lsu_req_priv_i,
  input  logic              lsu_req_store_i,
  output logic              lsu_rsp_valid_o,
  input  logic              lsu_rsp_ready_i,
  output logic              lsu_rsp_allow_o,
  output logic              lsu_rsp_store_o,
  output logic [PLEN-1:0]   pmp_addr_o,
  output logic [1:0]        pmp_priv_o,
  output logic [2:0]        pmp_access_o,
  input  logic              pmp_allow_i,
  input  logic              cfg_write_i,
  output logic [CNT_W-1:0]  deny_cnt_if_o,
  output logic [CNT_W-1:0]  deny_cnt_lsu_o
);

  pmp_check_rsp_t   r_if_rsp;
  pmp_check_rsp_t   r_lsu_rsp;
  logic [CNT_W-1:0] r_deny_if;
  logic [CNT_W-1:0] r_deny_lsu;

  logic w_if_free, w_lsu_free, w_arb_en;
  logic w_gnt_if, w_gnt_lsu;

  // A full slot that is being popped this cycle may be refilled at the edge
  assign w_if_free  = !r_if_rsp.valid  || if_rsp_ready_i;
  assign w_lsu_free = !r_lsu_rsp.valid || lsu_rsp_ready_i;
  assign w_arb_en   = !cfg_write_i && !rst_i;

  pmp_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (w_arb_en),
    .req_if_i  (if_req_valid_i  && w_if_free),
    .req_lsu_i (lsu_req_valid_i && w_lsu_free),
    .gnt_if_o  (w_gnt_if),
    .gnt_lsu_o (w_gnt_lsu)
  );

  assign if_req_ready_o  = w_gnt_if;
  assign lsu_req_ready_o = w_gnt_lsu;

  always_comb begin
    pmp_addr_o   = '0;
    pmp_priv_o   = '0;
    pmp_access_o = c_ACCESS_NONE;
    if (w_gnt_if) begin
      pmp_addr_o   = if_req_paddr_i;
      pmp_priv_o   = if_req_priv_i;
      pmp_access_o = c_ACCESS_EXEC;
    end else if (w_gnt_lsu) begin
      pmp_addr_o   = lsu_req_paddr_i;
      pmp_priv_o   = lsu_req_priv_i;
      pmp_access_o = lsu_req_store_i ? c_ACCESS_WRITE : c_ACCESS_READ;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_if_rsp  <= '0;
      r_lsu_rsp <= '0;
    end else begin
      if (w_gnt_if) begin
        r_if_rsp <= '{valid: 1'b1, allow: pmp_allow_i, store: 1'b0};
      end else if (if_rsp_ready_i) begin
        r_if_rsp.valid <= 1'b0;
      end
      if (w_gnt_lsu) begin
        r_lsu_rsp <= '{valid: 1'b1, allow: pmp_allow_i, store: lsu_req_store_i};
      end else if (lsu_rsp_ready_i) begin
        r_lsu_rsp.valid <= 1'b0;
      end
    end
  end

  // Saturating deny counters, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_deny_if  <= '0;
      r_deny_lsu <= '0;
    end else begin
      if (w_gnt_if && !pmp_allow_i && (r_deny_if != '1)) begin
        r_deny_if <= r_deny_if + 1'b1;
      end
      if (w_gnt_lsu && !pmp_allow_i && (r_deny_lsu != '1)) begin
        r_deny_lsu <= r_deny_lsu + 1'b1;
      end
    end
  end

  assign if_rsp_valid_o  = r_if_rsp.valid;
  assign if_rsp_allow_o  = r_if_rsp.allow;
  assign lsu_rsp_valid_o = r_lsu_rsp.valid;
  assign lsu_rsp_allow_o = r_lsu_rsp.allow;
  assign lsu_rsp_store_o = r_lsu_rsp.store;
  assign deny_cnt_if_o   = r_deny_if;
  assign deny_cnt_lsu_o  = r_deny_lsu;

endmodule : pmp_check_arb
`default_nettype wire

// File: tb/tb_pmp_check_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pmp_check_arb : directed + random bench with a transaction-level model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_pmp_check_arb;

  localparam int PLEN  = 34;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_allow;
  logic [PLEN-1:0]   if_req_paddr, lsu_req_paddr, pmp_addr;
  logic [1:0]        if_req_priv, lsu_req_priv, pmp_priv;
  logic              lsu_req_valid, lsu_req_ready, lsu_req_store;
  logic              lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_allow, lsu_rsp_store;
  logic [2:0]        pmp_access;
  logic              pmp_allow, cfg_write;
  logic [CNT_W-1:0]  deny_cnt_if, deny_cnt_lsu;

  int checks = 0;
  int errors = 0;

  // Reference state: response slots, deny tallies, who was served last
  bit m_if_v, m_if_a, m_lsu_v, m_lsu_a, m_lsu_s;
  int m_cnt_if, m_cnt_lsu;
  int m_last;  // 0 = IF served last, 1 = LSU served last

  always #5 clk = ~clk;

  pmp_check_arb #(.PLEN(PLEN), .CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_req_valid_i  (if_req_valid),
    .if_req_ready_o  (if_req_ready),
    .if_req_paddr_i  (if_req_paddr),
    .if_req_priv_i   (if_req_priv),
    .if_rsp_valid_o  (if_rsp_valid),
    .if_rsp_ready_i  (if_rsp_ready),
    .if_rsp_allow_o  (if_rsp_allow),
    .lsu_req_valid_i (lsu_req_valid),
    .lsu_req_ready_o (lsu_req_ready),
    .lsu_req_paddr_i (lsu_req_paddr),
    .lsu_req_priv_i  (lsu_req_priv),
    .lsu_req_store_i (lsu_req_store),
    .lsu_rsp_valid_o (lsu_rsp_valid),
    .lsu_rsp_ready_i (lsu_rsp_ready),
    .lsu_rsp_allow_o (lsu_rsp_allow),
    .lsu_rsp_store_o (lsu_rsp_store),
    .pmp_addr_o      (pmp_addr),
    .pmp_priv_o      (pmp_priv),
    .pmp_access_o    (pmp_access),
    .pmp_allow_i     (pmp_allow),
    .cfg_write_i     (cfg_write),
    .deny_cnt_if_o   (deny_cnt_if),
    .deny_cnt_lsu_o  (deny_cnt_lsu)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_if_v = 0; m_if_a = 0; m_lsu_v = 0; m_lsu_a = 0; m_lsu_s = 0;
    m_cnt_if = 0; m_cnt_lsu = 0; m_last = 1;
  endtask

  // One cycle: check everything mid-cycle against the model, then advance
  task automatic cyc();
    bit ei, el, gi, gl;
    logic [PLEN-1:0] e_addr;
    logic [1:0] e_priv;
    logic [2:0] e_acc;
    @(negedge clk);
    ei = if_req_valid  && (!m_if_v  || if_rsp_ready)  && !cfg_write && !rst;
    el = lsu_req_valid && (!m_lsu_v || lsu_rsp_ready) && !cfg_write && !rst;
    if (ei && el) begin gi = (m_last == 1); gl = !gi; end
    else begin gi = ei; gl = el; end
    e_addr = gi ? if_req_paddr : (gl ? lsu_req_paddr : '0);
    e_priv = gi ? if_req_priv  : (gl ? lsu_req_priv  : 2'b00);
    e_acc  = gi ? 3'b100 : (gl ? (lsu_req_store ? 3'b010 : 3'b001) : 3'b000);
    check("if_req_ready",  if_req_ready,  gi);
    check("lsu_req_ready", lsu_req_ready, gl);
    check("pmp_addr",      pmp_addr,      e_addr);
    check("pmp_priv",      pmp_priv,      e_priv);
    check("pmp_access",    pmp_access,    e_acc);
    check("if_rsp_valid",  if_rsp_valid,  m_if_v);
    check("lsu_rsp_valid", lsu_rsp_valid, m_lsu_v);
    if (m_if_v)  check("if_rsp_allow",  if_rsp_allow,  m_if_a);
    if (m_lsu_v) begin
      check("lsu_rsp_allow", lsu_rsp_allow, m_lsu_a);
      check("lsu_rsp_store", lsu_rsp_store, m_lsu_s);
    end
    check("deny_cnt_if",  deny_cnt_if,  m_cnt_if);
    check("deny_cnt_lsu", deny_cnt_lsu, m_cnt_lsu);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (gi) begin
        m_if_v = 1; m_if_a = pmp_allow; m_last = 0;
        if (!pmp_allow && m_cnt_if < CMAX) m_cnt_if++;
      end else if (if_rsp_ready) m_if_v = 0;
      if (gl) begin
        m_lsu_v = 1; m_lsu_a = pmp_allow; m_lsu_s = lsu_req_store; m_last = 1;
        if (!pmp_allow && m_cnt_lsu < CMAX) m_cnt_lsu++;
      end else if (lsu_rsp_ready) m_lsu_v = 0;
    end
    #1;
  endtask

  initial begin
    rst = 1; cfg_write = 0; pmp_allow = 0;
    if_req_valid = 0; if_req_paddr = '0; if_req_priv = 0; if_rsp_ready = 1;
    lsu_req_valid = 0; lsu_req_paddr = '0; lsu_req_priv = 0; lsu_req_store = 0; lsu_rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cyc();  // reset still high: no grants, outputs cleared
    rst = 0;
    check("rst_if_allow",   if_rsp_allow,  1'b0);
    check("rst_lsu_allow",  lsu_rsp_allow, 1'b0);
    check("rst_lsu_store",  lsu_rsp_store, 1'b0);
    cyc();

    // IF alone, M-mode, allowed
    if_req_valid = 1; if_req_paddr = 34'h0_8000_0000; if_req_priv = 2'b11; pmp_allow = 1;
    cyc();
    if_req_valid = 0;
    cyc();

    // Both requesting, consumers always ready: alternating grants
    if_req_valid = 1; lsu_req_valid = 1; lsu_req_store = 1;
    lsu_req_paddr = 34'h1_0000_1000; lsu_req_priv = 2'b01;
    repeat (4) cyc();

    // IF consumer stalled: LSU gets every cycle, IF verdict held
    if_rsp_ready = 0; lsu_req_store = 0; pmp_allow = 0;
    repeat (4) cyc();
    if_rsp_ready = 1;

    // CSR write blocks grants; IF wins afterwards
    cfg_write = 1;
    repeat (2) cyc();
    cfg_write = 0;
    cyc();
    cyc();

    // 17 denied LSU grants saturate the 4-bit counter
    if_req_valid = 0; lsu_req_valid = 1; pmp_allow = 0;
    repeat (17) cyc();
    check("lsu_cnt_saturated", deny_cnt_lsu, CMAX);

    // Reset with a full LSU slot, then a conflict goes to IF
    lsu_rsp_ready = 0; lsu_req_valid = 1;
    cyc();
    lsu_req_valid = 0;
    rst = 1;
    cyc();
    rst = 0;
    check("post_rst_lsu_valid", lsu_rsp_valid, 1'b0);
    check("post_rst_cnt",       deny_cnt_lsu,  '0);
    lsu_rsp_ready = 1; if_req_valid = 1; lsu_req_valid = 1;
    cyc();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if_req_valid  = $urandom_range(0, 3) != 0;
      lsu_req_valid = $urandom_range(0, 3) != 0;
      if_rsp_ready  = $urandom_range(0, 2) != 0;
      lsu_rsp_ready = $urandom_range(0, 2) != 0;
      if_req_paddr  = {$urandom, $urandom} & 34'h3_FFFF_FFFF;
      lsu_req_paddr = {$urandom, $urandom} & 34'h3_FFFF_FFFF;
      if_req_priv   = 2'($urandom_range(0, 3));
      lsu_req_priv  = 2'($urandom_range(0, 3));
      lsu_req_store = 1'($urandom_range(0, 1));
      pmp_allow     = 1'($urandom_range(0, 1));
      cfg_write     = $urandom_range(0, 9) == 0;
      rst           = $urandom_range(0, 99) == 0;
      cyc();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pmp_check_arb
`default_nettype wire
